// File: rtl/insight_event_counter.sv
// insight_event_counter: qualified Insight event counter with threshold match, sticky overflow/match, irq and 32-bit register port (clock/reset, event_sel/inc in, reg_* access, match_irq/overflow out)
module insight_event_counter #(
  parameter int COUNT_WIDTH = 64,
  parameter int SEL_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SEL_WIDTH-1:0] event_sel,
  input  logic                 inc,
  input  logic                 reg_wr_en,
  input  logic                 reg_rd_en,
  input  logic [2:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 reg_rvalid,
  output logic                 match_irq,
  output logic                 overflow
);
  logic [3:0] ctrl_q, ctrl_d;
  logic [SEL_WIDTH-1:0] mask_q, mask_d, sel_q;
  logic inc_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, thr_q, thr_d, nxt;
  logic ovf_q, ovf_d, match_q, match_d, rvalid_q;
  logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic [63:0] cnt64, thr64;
  logic [31:0] regs [8];
  logic [6:0] wr;
  logic qual, cnt_wr, hit, wrap;
  always_comb begin
    cnt64 = 64'(cnt_q);
    thr64 = 64'(thr_q);
    wr = reg_wr_en ? 7'(8'd1 << reg_addr) : 7'd0;
    cnt_wr = wr[2] | wr[3];
    qual = inc_q & ctrl_q[0] & |(sel_q & mask_q) & ~(ctrl_q[2] & ovf_q);
    nxt = cnt_q + COUNT_WIDTH'(1);
    hit = qual & ~cnt_wr & (nxt == thr_q);
    wrap = qual & ~cnt_wr & (&cnt_q);
    cnt_d = wr[2] ? COUNT_WIDTH'({cnt64[63:32], reg_wdata}) :
            wr[3] ? COUNT_WIDTH'({reg_wdata, cnt64[31:0]}) :
            qual ? ((hit & ctrl_q[1]) ? '0 : nxt) : cnt_q;
    thr_d = wr[4] ? COUNT_WIDTH'({thr64[63:32], reg_wdata}) :
            wr[5] ? COUNT_WIDTH'({reg_wdata, thr64[31:0]}) : thr_q;
    ctrl_d = wr[0] ? reg_wdata[3:0] : ctrl_q;
    mask_d = wr[1] ? reg_wdata[SEL_WIDTH-1:0] : mask_q;
    ovf_d = (ovf_q & ~(wr[6] & reg_wdata[0])) | wrap;
    match_d = (match_q & ~(wr[6] & reg_wdata[1])) | hit;
    regs[0] = {28'd0, ctrl_q};
    regs[1] = 32'(mask_q);
    regs[2] = cnt64[31:0];
    regs[3] = shadow_q;
    regs[4] = thr64[31:0];
    regs[5] = thr64[63:32];
    regs[6] = {30'd0, match_q, ovf_q};
    regs[7] = 32'd0;
    shadow_d = (reg_rd_en && reg_addr == 3'd2) ? cnt64[63:32] : shadow_q;
    rdata_d = reg_rd_en ? regs[reg_addr] : rdata_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= '0;
      mask_q <= '1;
      sel_q <= '0;
      inc_q <= 1'b0;
      cnt_q <= '0;
      thr_q <= '0;
      ovf_q <= 1'b0;
      match_q <= 1'b0;
      shadow_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      sel_q <= event_sel;
      inc_q <= inc;
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      ovf_q <= ovf_d;
      match_q <= match_d;
      shadow_q <= shadow_d;
      rdata_q <= rdata_d;
      rvalid_q <= reg_rd_en;
    end
  end
  assign reg_rdata = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign overflow = ovf_q;
  assign match_irq = match_q & ctrl_q[3];
endmodule

// File: tb/tb_insight_event_counter.sv
// tb_insight_event_counter: randomized and directed checks of insight_event_counter against a behavioural model
module tb_insight_event_counter;
  logic clock = 0, reset = 1, inc = 0, reg_wr_en = 0, reg_rd_en = 0;
  logic [31:0] event_sel = 0, reg_wdata = 0;
  logic [2:0] reg_addr = 0;
  logic [31:0] reg_rdata;
  logic reg_rvalid, match_irq, overflow;
  int total = 0, bad = 0;
  logic [63:0] m_cnt, m_thr;
  logic [3:0] m_ctrl;
  logic [31:0] m_mask, m_psel, m_rdata, m_shadow;
  logic m_ovf, m_match, m_pinc, m_rvalid;

  always #5 clock = ~clock;

  insight_event_counter dut (
    .clock(clock), .reset(reset), .event_sel(event_sel), .inc(inc),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .match_irq(match_irq), .overflow(overflow)
  );

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_ctrl};
      3'd1: return m_mask;
      3'd2: return m_cnt[31:0];
      3'd3: return m_shadow;
      3'd4: return m_thr[31:0];
      3'd5: return m_thr[63:32];
      3'd6: return {30'd0, m_match, m_ovf};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    bit q, cw, set_ovf, set_match;
    logic [63:0] nx;
    if (reset) begin
      m_cnt = 0; m_thr = 0; m_ctrl = 0; m_mask = 32'hFFFF_FFFF; m_psel = 0;
      m_rdata = 0; m_shadow = 0; m_ovf = 0; m_match = 0; m_pinc = 0; m_rvalid = 0;
    end else begin
      q = m_pinc && m_ctrl[0] && ((m_psel & m_mask) != 0) && !(m_ctrl[2] && m_ovf);
      cw = reg_wr_en && (reg_addr == 3'd2 || reg_addr == 3'd3);
      nx = m_cnt + 64'd1;
      set_ovf = q && !cw && (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
      set_match = q && !cw && (nx == m_thr);
      if (reg_rd_en) begin
        m_rdata = m_read(reg_addr);
        if (reg_addr == 3'd2) m_shadow = m_cnt[63:32];
      end
      m_rvalid = reg_rd_en;
      if (reg_wr_en && reg_addr == 3'd6) begin
        if (reg_wdata[0]) m_ovf = 0;
        if (reg_wdata[1]) m_match = 0;
      end
      if (set_ovf) m_ovf = 1;
      if (set_match) m_match = 1;
      if (q && !cw) m_cnt = (set_match && m_ctrl[1]) ? 64'd0 : nx;
      if (reg_wr_en)
        case (reg_addr)
          3'd0: m_ctrl = reg_wdata[3:0];
          3'd1: m_mask = reg_wdata;
          3'd2: m_cnt[31:0] = reg_wdata;
          3'd3: m_cnt[63:32] = reg_wdata;
          3'd4: m_thr[31:0] = reg_wdata;
          3'd5: m_thr[63:32] = reg_wdata;
          default: ;
        endcase
      m_pinc = inc;
      m_psel = event_sel;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr_en = 1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr_en = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_rd_en = 1; reg_addr = a;
    tick();
    reg_rd_en = 0;
    d = reg_rdata;
  endtask

  task automatic pulse(input int n, input logic [31:0] s);
    for (int i = 0; i < n; i++) begin
      inc = 1; event_sel = s;
      tick();
    end
    inc = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1;
    idle(2);
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", reg_rvalid); end
    total++; if (reg_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
    total++; if ({overflow, match_irq} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, match_irq}); end
    reset = 0;
    rd(3'd1, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_mask got=%h exp=ffffffff", d); end
    rd(3'd0, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_count_basic();
    logic [31:0] d;
    wr(3'd0, 32'd1);
    wr(3'd1, 32'h4);
    pulse(1, 32'h4);
    rd(3'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL basic_latency1 got=%h exp=0", d); end
    rd(3'd2, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL basic_latency2 got=%h exp=1", d); end
    pulse(9, 32'h4);
    pulse(5, 32'h8);
    idle(2);
    rd(3'd2, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL basic_lo got=%h exp=a", d); end
    rd(3'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL basic_hi got=%h exp=0", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    pulse(1, 32'h4);
    idle(2);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", overflow); end
    rd(3'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_lo got=%h exp=0", d); end
    rd(3'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", d); end
    wr(3'd0, 32'h5);
    pulse(3, 32'h4);
    idle(2);
    rd(3'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL freeze_lo got=%h exp=0", d); end
    wr(3'd6, 32'h1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL w1c_ovf got=%b exp=0", overflow); end
    pulse(1, 32'h4);
    idle(2);
    rd(3'd2, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL resume_lo got=%h exp=1", d); end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd5);
    wr(3'd5, 32'd0);
    wr(3'd6, 32'h3);
    wr(3'd0, 32'hB);
    for (int k = 1; k <= 9; k++) begin
      inc = (k <= 7); event_sel = 32'h4;
      tick();
      total++; if (match_irq !== (k >= 6)) begin bad++; $display("FAIL thr_irq_%0d got=%b exp=%b", k, match_irq, k >= 6); end
    end
    inc = 0;
    rd(3'd2, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL thr_final got=%h exp=2", d); end
    rd(3'd6, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL thr_status got=%h exp=2", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(3'd0, 32'h1);
    wr(3'd6, 32'h3);
    wr(3'd2, 32'd100);
    inc = 1; event_sel = 32'h4;
    tick();
    inc = 0;
    wr(3'd2, 32'd7);
    idle(1);
    rd(3'd2, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL collision_lo got=%h exp=7", d); end
  endtask

  task automatic test_tear();
    logic [31:0] lo, hi;
    wr(3'd3, 32'd1);
    wr(3'd2, 32'hFFFF_FFFE);
    inc = 1; event_sel = 32'h4;
    tick();
    rd(3'd2, lo);
    rd(3'd3, hi);
    inc = 0;
    total++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin bad++; $display("FAIL tear_pair got=%h exp=1fffffffe", {hi, lo}); end
    idle(2);
    rd(3'd2, lo);
    rd(3'd3, hi);
    total++; if ({hi, lo} !== 64'h2_0000_0001) begin bad++; $display("FAIL tear_after got=%h exp=200000001", {hi, lo}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(3'd1, 32'h4);
    pulse(1, 32'h4);
    reset = 1;
    tick();
    reset = 0;
    total++; if (reg_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid got=%b exp=0", reg_rvalid); end
    wr(3'd0, 32'h1);
    idle(2);
    rd(3'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rmid_cnt got=%h exp=0", d); end
    rd(3'd6, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rmid_status got=%h exp=0", d); end
    rd(3'd1, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rmid_mask got=%h exp=ffffffff", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    reg_wr_en = 1; reg_rd_en = 1; reg_addr = 3'd0; reg_wdata = 32'hFFFF_FFFF;
    tick();
    reg_wr_en = 0; reg_rd_en = 0;
    total++; if ({reg_rvalid, reg_rdata} !== {1'b1, 32'h1}) begin bad++; $display("FAIL rdwr_pre got=%b/%h exp=1/1", reg_rvalid, reg_rdata); end
    tick();
    total++; if ({reg_rvalid, reg_rdata} !== {1'b0, 32'h1}) begin bad++; $display("FAIL rvalid_pulse got=%b/%h exp=0/1", reg_rvalid, reg_rdata); end
    rd(3'd0, d);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL ctrl_bits got=%h exp=f", d); end
    wr(3'd7, 32'hDEAD_BEEF);
    rd(3'd7, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reserved got=%h exp=0", d); end
  endtask

  task automatic test_random();
    int r;
    reset = 1;
    tick();
    reset = 0;
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h3F);
    wr(3'd4, 32'd20);
    for (int n = 0; n < 3000; n++) begin
      inc = ($urandom % 10) < 6;
      event_sel = 32'h1 << $urandom_range(0, 7);
      reg_rd_en = ($urandom % 4) == 0;
      reg_wr_en = ($urandom % 16) == 0;
      reg_addr = 3'($urandom_range(0, 7));
      r = $urandom % 4;
      reg_wdata = r == 0 ? $urandom : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'($urandom_range(0, 24)) : 32'hFFFF_FFF0;
      reset = ($urandom % 700) == 0;
      tick();
      total++; if (reg_rvalid !== m_rvalid) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, reg_rvalid, m_rvalid); end
      if (m_rvalid) begin
        total++; if (reg_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%0d got=%h exp=%h", n, reg_addr, reg_rdata, m_rdata); end
      end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
      total++; if (match_irq !== (m_match && m_ctrl[3])) begin bad++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, match_irq, m_match && m_ctrl[3]); end
    end
    inc = 0; reg_rd_en = 0; reg_wr_en = 0; reset = 0;
  endtask

  initial begin
    test_reset();
    test_count_basic();
    test_wrap();
    test_threshold();
    test_collision();
    test_tear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
